hazard_stall_unit: RTL and testbench

//  Producer side of the EX/MEM/WB forwarding interface. Tracks the destination,

---
 rtl/hazard_stall_unit_if.sv | 42 ++++
 rtl/hazard_stall_unit.sv | 75 +++++++
 tb/tb_hazard_stall_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID-side request and forwarding-slot signals of the hazard/stall unit
interface hazard_stall_unit_if #(
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_writereg;
    logic             id_regwrite;
    logic             id_memtoreg;
    logic             id_multi;
    logic             flush;

    logic             stall;
    logic             bubble_ex;
    logic             ex_busy;
    logic [REG_W-1:0] writeregEX;
    logic [REG_W-1:0] writeregMEM;
    logic [REG_W-1:0] writeregWB;
    logic             RegWriteMEM;
    logic             RegWriteWB;
    logic             MemtoRegMEM;
    logic             MemtoRegWB;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_writereg, id_regwrite, id_memtoreg, id_multi, flush,
        input  stall, bubble_ex, ex_busy,
        input  writeregEX, writeregMEM, writeregWB,
        input  RegWriteMEM, RegWriteWB, MemtoRegMEM, MemtoRegWB
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_writereg, id_regwrite, id_memtoreg, id_multi, flush,
        output stall, bubble_ex, ex_busy,
        output writeregEX, writeregMEM, writeregWB,
        output RegWriteMEM, RegWriteWB, MemtoRegMEM, MemtoRegWB
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - EX/MEM/WB destination tracking with load-use and multi-cycle EX stall control
module hazard_stall_unit #(
    parameter int REG_W     = 5,
    parameter int MULTI_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_stall_unit_if.slave    hs
);
    localparam int CNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 1);

    typedef struct packed {
        logic [REG_W-1:0] wr;
        logic             rw;
        logic             mt;
    } slot_t;

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    logic [CNT_W-1:0] r_cnt;

    logic  w_busy;
    logic  w_match;
    logic  w_load_use;
    logic  w_flush;
    logic  w_issue;
    slot_t w_id_slot;

    always_comb begin
        w_busy     = (r_cnt != '0);
        w_match    = (hs.id_use_rs && (hs.id_rs == r_ex.wr)) ||
                     (hs.id_use_rt && (hs.id_rt == r_ex.wr));
        w_load_use = hs.id_valid && r_ex.mt && r_ex.rw && w_match;
        // A multi-cycle op in EX can never be a branch, so flush is meaningless while busy.
        w_flush    = hs.flush && !w_busy;
        w_issue    = hs.id_valid && !w_flush && !w_load_use && !w_busy;
        w_id_slot.wr = hs.id_writereg;
        w_id_slot.rw = hs.id_regwrite && (hs.id_writereg != '0);
        w_id_slot.mt = hs.id_memtoreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_wb  <= r_mem;
            r_mem <= '0;
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_issue ? w_id_slot : '0;
            if (w_issue && hs.id_multi) begin
                r_cnt <= CNT_LOAD;
            end
        end
    end

    // Busy dominates; a killed ID instruction cannot hold the front end.
    assign hs.stall       = !rst && (w_busy || (w_load_use && !w_flush));
    assign hs.bubble_ex   = !rst && !w_busy && hs.id_valid && (w_flush || w_load_use);
    assign hs.ex_busy     = w_busy;
    assign hs.writeregEX  = r_ex.wr;
    assign hs.writeregMEM = r_mem.wr;
    assign hs.writeregWB  = r_wb.wr;
    assign hs.RegWriteMEM = r_mem.rw;
    assign hs.RegWriteWB  = r_wb.rw;
    assign hs.MemtoRegMEM = r_mem.mt;
    assign hs.MemtoRegWB  = r_wb.mt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;
    logic clk;
    logic rst;

    hazard_stall_unit_if #(.REG_W(5)) hs ();

    hazard_stall_unit #(.REG_W(5), .MULTI_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hs  (hs)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] wr;
        logic       rw;
        logic       mt;
        logic       mul;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       bub;
        logic       busy;
        logic [4:0] wex;
        logic [4:0] wmem;
        logic [4:0] wwb;
        logic       rwm;
        logic       rww;
        logic       mtm;
        logic       mtw;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t S(input int v, input int rs, input int urs, input int rt, input int urt,
                                input int wr, input int rw, input int mt, input int mul, input int fl);
        stim_t s;
        s.v = 1'(v);   s.rs = 5'(rs); s.urs = 1'(urs); s.rt = 5'(rt); s.urt = 1'(urt);
        s.wr = 5'(wr); s.rw = 1'(rw); s.mt = 1'(mt);   s.mul = 1'(mul); s.fl = 1'(fl);
        return s;
    endfunction

    function automatic obs_t E(input int st, input int bb, input int by, input int we, input int wm,
                               input int ww, input int rm, input int rw, input int mm, input int mw);
        obs_t o;
        o.stall = 1'(st); o.bub = 1'(bb); o.busy = 1'(by);
        o.wex = 5'(we);   o.wmem = 5'(wm); o.wwb = 5'(ww);
        o.rwm = 1'(rm);   o.rww = 1'(rw);  o.mtm = 1'(mm); o.mtw = 1'(mw);
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.stall = hs.stall;       o.bub = hs.bubble_ex;     o.busy = hs.ex_busy;
        o.wex = hs.writeregEX;    o.wmem = hs.writeregMEM;  o.wwb = hs.writeregWB;
        o.rwm = hs.RegWriteMEM;   o.rww = hs.RegWriteWB;
        o.mtm = hs.MemtoRegMEM;   o.mtw = hs.MemtoRegWB;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        hs.id_valid    = s.v;
        hs.id_rs       = s.rs;
        hs.id_use_rs   = s.urs;
        hs.id_rt       = s.rt;
        hs.id_use_rt   = s.urt;
        hs.id_writereg = s.wr;
        hs.id_regwrite = s.rw;
        hs.id_memtoreg = s.mt;
        hs.id_multi    = s.mul;
        hs.flush       = s.fl;
    endtask

    task automatic drain();
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        sb_t  it;
        obs_t act;
        rst = 1'b1;
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        it.tag = "reset_hold"; it.exp = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(it);
        #3;
        it = sb.pop_front(); act = observe(); n_vec++;
        if (act !== it.exp) begin
            n_bad++; $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        it.tag = "reset_first"; it.exp = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(it);
        @(negedge clk);
        it = sb.pop_front(); act = observe(); n_vec++;
        if (act !== it.exp) begin
            n_bad++; $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t s[4]; obs_t e[4]; sb_t it; obs_t act;
        drain();
        s[0] = S(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); e[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = S(1, 3, 1, 0, 0, 4, 1, 0, 0, 0); e[1] = E(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        s[2] = s[1];                            e[2] = E(0, 0, 0, 0, 3, 0, 1, 0, 1, 0);
        s[3] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = E(0, 0, 0, 4, 0, 3, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]); it.tag = "load_use"; it.exp = e[i]; sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front(); act = observe(); n_vec++;
            if (act !== it.exp) begin
                n_bad++; $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, act, it.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_hazard();
        stim_t s[3]; obs_t e[3]; sb_t it; obs_t act;
        drain();
        s[0] = S(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); e[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = S(1, 5, 1, 0, 0, 6, 1, 0, 0, 0); e[1] = E(0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        s[2] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = E(0, 0, 0, 6, 5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(s[i]); it.tag = "no_hazard"; it.exp = e[i]; sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front(); act = observe(); n_vec++;
            if (act !== it.exp) begin
                n_bad++; $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, act, it.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r0_dest();
        stim_t s[3]; obs_t e[3]; sb_t it; obs_t act;
        drain();
        s[0] = S(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); e[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = S(1, 0, 1, 0, 0, 2, 1, 0, 0, 0); e[1] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[2] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = E(0, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(s[i]); it.tag = "r0_dest"; it.exp = e[i]; sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front(); act = observe(); n_vec++;
            if (act !== it.exp) begin
                n_bad++; $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, act, it.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multi_cycle();
        stim_t s[8]; obs_t e[8]; sb_t it; obs_t act;
        drain();
        s[0] = S(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); e[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = S(1, 0, 0, 0, 0, 7, 1, 0, 1, 0); e[1] = E(0, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        s[2] = S(1, 7, 1, 0, 0, 8, 1, 0, 0, 0); e[2] = E(1, 0, 1, 7, 9, 0, 1, 0, 0, 0);
        s[3] = S(1, 7, 1, 0, 0, 8, 1, 0, 0, 1); e[3] = E(1, 0, 1, 7, 0, 9, 0, 1, 0, 0);
        s[4] = s[2];                            e[4] = E(1, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        s[5] = s[2];                            e[5] = E(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
        s[6] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[6] = E(0, 0, 0, 8, 7, 0, 1, 0, 0, 0);
        s[7] = s[6];                            e[7] = E(0, 0, 0, 0, 8, 7, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(s[i]); it.tag = "multi_cycle"; it.exp = e[i]; sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front(); act = observe(); n_vec++;
            if (act !== it.exp) begin
                n_bad++; $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, act, it.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_load_use();
        stim_t s[4]; obs_t e[4]; sb_t it; obs_t act;
        drain();
        s[0] = S(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); e[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = S(1, 3, 1, 0, 0, 4, 1, 0, 0, 1); e[1] = E(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        s[2] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = E(0, 0, 0, 0, 3, 0, 1, 0, 1, 0);
        s[3] = s[2];                            e[3] = E(0, 0, 0, 0, 0, 3, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]); it.tag = "flush_load_use"; it.exp = e[i]; sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front(); act = observe(); n_vec++;
            if (act !== it.exp) begin
                n_bad++; $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, act, it.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[6]; obs_t e[6]; sb_t it; obs_t act;
        drain();
        s[0] = S(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); e[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = S(1, 3, 1, 0, 0, 4, 1, 1, 0, 0); e[1] = E(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        s[2] = s[1];                            e[2] = E(0, 0, 0, 0, 3, 0, 1, 0, 1, 0);
        s[3] = S(1, 0, 0, 4, 1, 5, 1, 0, 0, 0); e[3] = E(1, 1, 0, 4, 0, 3, 0, 1, 0, 1);
        s[4] = s[3];                            e[4] = E(0, 0, 0, 0, 4, 0, 1, 0, 1, 0);
        s[5] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = E(0, 0, 0, 5, 0, 4, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]); it.tag = "back_to_back"; it.exp = e[i]; sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front(); act = observe(); n_vec++;
            if (act !== it.exp) begin
                n_bad++; $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, act, it.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        sb_t it; obs_t act;
        drain();
        drive(S(1, 0, 0, 0, 0, 9, 1, 0, 0, 0));
        @(posedge clk); #1;
        drive(S(1, 0, 0, 0, 0, 7, 1, 0, 1, 0));
        @(posedge clk); #1;
        it.tag = "pre_reset_busy"; it.exp = E(1, 0, 1, 7, 9, 0, 1, 0, 0, 0); sb.push_back(it);
        #1;
        it = sb.pop_front(); act = observe(); n_vec++;
        if (act !== it.exp) begin
            n_bad++; $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
        end
        it.tag = "async_reset_mid_busy"; it.exp = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(it);
        rst = 1'b1;
        #1;
        it = sb.pop_front(); act = observe(); n_vec++;
        if (act !== it.exp) begin
            n_bad++; $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        it.tag = "after_async_reset"; it.exp = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(it);
        @(negedge clk);
        it = sb.pop_front(); act = observe(); n_vec++;
        if (act !== it.exp) begin
            n_bad++; $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_r0_dest();
        test_multi_cycle();
        test_flush_load_use();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
